// File: rtl/list_port_arb.sv
// list_port_arb: shares the two list-controller access ports between NUM_REQ
// requesters. Round-robin picks an older grant (port0) and a non-conflicting
// younger grant (port1) each cycle; results return as a 1-cycle registered pulse.
// Optional feature macro: ARB_STATS_EN (grant/conflict statistics counters).
module list_port_arb #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned LISTS_DEPTH = 4,
  parameter int unsigned INDEX_LENTH = 4,
  localparam int unsigned TAG_W      = (LISTS_DEPTH > 1) ? $clog2(LISTS_DEPTH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
`ifdef ARB_STATS_EN
  input  logic                           stat_clr,
  output logic [31:0]                    stat_grant_cnt,
  output logic [15:0]                    stat_conflict_cnt,
`endif
  input  logic                           arb_en,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INDEX_LENTH-1:0] req_index,
  input  logic [NUM_REQ*2-1:0]           req_cmd,
  input  logic [NUM_REQ*TAG_W-1:0]       req_tag,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [NUM_REQ*3-1:0]           rsp_status,
  output logic [NUM_REQ*TAG_W-1:0]       rsp_tag,
  output logic                           acc_req_0,
  output logic [INDEX_LENTH-1:0]         acc_index_0,
  output logic [1:0]                     acc_cmd_0,
  output logic [TAG_W-1:0]               acc_tag_0,
  input  logic [2:0]                     acc_status_0,
  input  logic [TAG_W-1:0]               return_tag_0,
  output logic                           acc_req_1,
  output logic [INDEX_LENTH-1:0]         acc_index_1,
  output logic [1:0]                     acc_cmd_1,
  output logic [TAG_W-1:0]               acc_tag_1,
  input  logic [2:0]                     acc_status_1,
  input  logic [TAG_W-1:0]               return_tag_1
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0]  CMD_ILLEGAL = 2'b11;
  localparam logic [2:0]  STATUS_ILLEGAL = 3'b111;

  logic [INDEX_LENTH-1:0] idx_arr [NUM_REQ];
  logic [1:0]             cmd_arr [NUM_REQ];
  logic [TAG_W-1:0]       tag_arr [NUM_REQ];

  logic [PTR_W-1:0]       rr_ptr_q;
  logic [PTR_W-1:0]       rr_ptr_d;

  logic                   found_a;
  logic                   found_b;
  logic                   conflict;
  logic [PTR_W-1:0]       a_idx;
  logic [PTR_W-1:0]       b_idx;
  logic [PTR_W-1:0]       skip_idx;

  logic                   grant_en;
  logic                   gnt_a;
  logic                   gnt_b;
  logic                   a_illegal;

  // Unpack the flat request buses into per-requester fields
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_arr[i] = req_index[i*INDEX_LENTH +: INDEX_LENTH];
      cmd_arr[i] = req_cmd[i*2 +: 2];
      tag_arr[i] = req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Round-robin scan: A is the first valid, B the next valid that neither
  // shares A's index nor carries an illegal command
  always_comb begin
    int unsigned r;
    found_a  = 1'b0;
    found_b  = 1'b0;
    conflict = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    skip_idx = '0;
    r        = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      r = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[r]) begin
        if (!found_a) begin
          found_a = 1'b1;
          a_idx   = PTR_W'(r);
        end else if (!found_b) begin
          if (idx_arr[r] == idx_arr[a_idx]) begin
            if (!conflict) begin
              skip_idx = PTR_W'(r);
            end
            conflict = 1'b1;
          end else if (cmd_arr[r] != CMD_ILLEGAL) begin
            found_b = 1'b1;
            b_idx   = PTR_W'(r);
          end
        end
      end
    end
  end

  assign grant_en  = arb_en & rst_n;
  assign gnt_a     = found_a & grant_en;
  assign gnt_b     = found_b & grant_en;
  assign a_illegal = (cmd_arr[a_idx] == CMD_ILLEGAL);

  // Drive handshakes and the two access ports straight from the grant
  always_comb begin
    req_ready   = '0;
    acc_req_0   = 1'b0;
    acc_index_0 = '0;
    acc_cmd_0   = '0;
    acc_tag_0   = '0;
    acc_req_1   = 1'b0;
    acc_index_1 = '0;
    acc_cmd_1   = '0;
    acc_tag_1   = '0;
    if (gnt_a) begin
      req_ready[a_idx] = 1'b1;
      if (!a_illegal) begin
        acc_req_0   = 1'b1;
        acc_index_0 = idx_arr[a_idx];
        acc_cmd_0   = cmd_arr[a_idx];
        acc_tag_0   = tag_arr[a_idx];
      end
    end
    if (gnt_b) begin
      req_ready[b_idx] = 1'b1;
      acc_req_1        = 1'b1;
      acc_index_1      = idx_arr[b_idx];
      acc_cmd_1        = cmd_arr[b_idx];
      acc_tag_1        = tag_arr[b_idx];
    end
  end

  // Next priority: first conflict-skipped requester, else one past the last grant
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_en) begin
      if (conflict) begin
        rr_ptr_d = skip_idx;
      end else if (found_b) begin
        rr_ptr_d = PTR_W'((32'(b_idx) + 1) % NUM_REQ);
      end else if (found_a) begin
        rr_ptr_d = PTR_W'((32'(a_idx) + 1) % NUM_REQ);
      end
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Capture port results into the owning requester's response slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_status <= '0;
      rsp_tag    <= '0;
    end else begin
      rsp_valid <= req_ready;
      if (gnt_a) begin
        rsp_status[32'(a_idx)*3 +: 3]         <= a_illegal ? STATUS_ILLEGAL : acc_status_0;
        rsp_tag[32'(a_idx)*TAG_W +: TAG_W]    <= a_illegal ? '0 : return_tag_0;
      end
      if (gnt_b) begin
        rsp_status[32'(b_idx)*3 +: 3]         <= acc_status_1;
        rsp_tag[32'(b_idx)*TAG_W +: TAG_W]    <= return_tag_1;
      end
    end
  end

`ifdef ARB_STATS_EN
  // Grant counter wraps; conflict counter saturates; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else if (stat_clr) begin
      stat_grant_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      stat_grant_cnt <= stat_grant_cnt + 32'(gnt_a) + 32'(gnt_b);
      if (conflict && grant_en && (stat_conflict_cnt != 16'hFFFF)) begin
        stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_list_port_arb.sv
// Directed bench for list_port_arb: grant/port checks inline, responses via a
// due-cycle scoreboard popped by a negedge monitor. Set ARB_STATS_EN to cover stats.
module tb_list_port_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IW      = 4;
  localparam int unsigned TW      = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*IW-1:0]   req_index;
  logic [NUM_REQ*2-1:0]    req_cmd;
  logic [NUM_REQ*TW-1:0]   req_tag;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [NUM_REQ*3-1:0]    rsp_status;
  logic [NUM_REQ*TW-1:0]   rsp_tag;
  logic                    acc_req_0, acc_req_1;
  logic [IW-1:0]           acc_index_0, acc_index_1;
  logic [1:0]              acc_cmd_0, acc_cmd_1;
  logic [TW-1:0]           acc_tag_0, acc_tag_1;
  logic [2:0]              acc_status_0, acc_status_1;
  logic [TW-1:0]           return_tag_0, return_tag_1;
`ifdef ARB_STATS_EN
  logic                    stat_clr;
  logic [31:0]             stat_grant_cnt;
  logic [15:0]             stat_conflict_cnt;
`endif

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned due;
    int unsigned id;
    logic [2:0]  st;
    logic [TW-1:0] tg;
  } exp_t;
  exp_t sbq[$];

  list_port_arb #(.NUM_REQ(NUM_REQ), .LISTS_DEPTH(4), .INDEX_LENTH(IW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef ARB_STATS_EN
    .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt), .stat_conflict_cnt(stat_conflict_cnt),
`endif
    .arb_en(arb_en), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_cmd(req_cmd), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_tag(rsp_tag),
    .acc_req_0(acc_req_0), .acc_index_0(acc_index_0), .acc_cmd_0(acc_cmd_0), .acc_tag_0(acc_tag_0),
    .acc_status_0(acc_status_0), .return_tag_0(return_tag_0),
    .acc_req_1(acc_req_1), .acc_index_1(acc_index_1), .acc_cmd_1(acc_cmd_1), .acc_tag_1(acc_tag_1),
    .acc_status_1(acc_status_1), .return_tag_1(return_tag_1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple combinational list-controller stand-in with distinct per-port results
  assign acc_status_0 = {acc_cmd_0[1], acc_index_0[1:0]};
  assign return_tag_0 = acc_tag_0 + 2'd1;
  assign acc_status_1 = {1'b1, acc_index_1[0], acc_cmd_1[0]};
  assign return_tag_1 = acc_tag_1 + 2'd2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // port: 0 = served on port0, 1 = served on port1, 2 = illegal command
  task automatic push_rsp(input int unsigned id, input int unsigned port,
                          input logic [IW-1:0] idx, input logic [1:0] cmd, input logic [TW-1:0] tag);
    exp_t e;
    e.due = cyc + 1;
    e.id  = id;
    case (port)
      0:       begin e.st = {cmd[1], idx[1:0]};       e.tg = tag + 2'd1; end
      1:       begin e.st = {1'b1, idx[0], cmd[0]};   e.tg = tag + 2'd2; end
      default: begin e.st = 3'b111;                   e.tg = '0;         end
    endcase
    sbq.push_back(e);
  endtask

  task automatic set_req(input int unsigned i, input logic [IW-1:0] idx,
                         input logic [1:0] cmd, input logic [TW-1:0] tag);
    req_index[i*IW +: IW] = idx;
    req_cmd[i*2 +: 2]     = cmd;
    req_tag[i*TW +: TW]   = tag;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire every response due this cycle and demand no others
  always @(negedge clk) begin : mon
    logic [NUM_REQ-1:0] m;
    exp_t e;
    m = '0;
    while (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      m[e.id] = 1'b1;
      chk($sformatf("rsp_status[%0d]", e.id), 32'(rsp_status[e.id*3 +: 3]), 32'(e.st));
      chk($sformatf("rsp_tag[%0d]", e.id), 32'(rsp_tag[e.id*TW +: TW]), 32'(e.tg));
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(m));
  end

  initial begin
    rst_n = 1'b0; arb_en = 1'b1;
    req_valid = 4'b1111; req_index = '0; req_cmd = '0; req_tag = '0;
`ifdef ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 2'b00, 2'(i));
    #3;
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset acc_req_0", 32'(acc_req_0), 0);
    chk("reset acc_req_1", 32'(acc_req_1), 0);
    chk("reset rsp_status", 32'(rsp_status), 0);
    chk("reset rsp_tag", 32'(rsp_tag), 0);
    next_cycle(); next_cycle();

    // Single read from requester 0
    rst_n = 1'b1;
    req_valid = 4'b0001; set_req(0, 4'd3, 2'b00, 2'd1);
    #1;
    chk("t1 req_ready", 32'(req_ready), 32'b0001);
    chk("t1 acc_req_0", 32'(acc_req_0), 1);
    chk("t1 acc_index_0", 32'(acc_index_0), 3);
    chk("t1 acc_tag_0", 32'(acc_tag_0), 1);
    chk("t1 acc_req_1", 32'(acc_req_1), 0);
    chk("t1 acc_index_1", 32'(acc_index_1), 0);
    push_rsp(0, 0, 4'd3, 2'b00, 2'd1);

    // Requester 3 alone, pointer wraps back to 0
    next_cycle();
    req_valid = 4'b1000; set_req(3, 4'd7, 2'b01, 2'd2);
    #1;
    chk("t1b req_ready", 32'(req_ready), 32'b1000);
    chk("t1b acc_index_0", 32'(acc_index_0), 7);
    push_rsp(3, 0, 4'd7, 2'b01, 2'd2);

    // All four valid, distinct indices: 0/1 then 2/3
    next_cycle();
    req_valid = 4'b1111;
    set_req(0, 4'd1, 2'b00, 2'd0); set_req(1, 4'd2, 2'b01, 2'd1);
    set_req(2, 4'd3, 2'b10, 2'd2); set_req(3, 4'd4, 2'b00, 2'd3);
    #1;
    chk("t2a req_ready", 32'(req_ready), 32'b0011);
    chk("t2a acc_index_0", 32'(acc_index_0), 1);
    chk("t2a acc_req_1", 32'(acc_req_1), 1);
    chk("t2a acc_index_1", 32'(acc_index_1), 2);
    chk("t2a acc_cmd_1", 32'(acc_cmd_1), 1);
    push_rsp(0, 0, 4'd1, 2'b00, 2'd0); push_rsp(1, 1, 4'd2, 2'b01, 2'd1);
    next_cycle();
    req_valid = 4'b1100;
    #1;
    chk("t2b req_ready", 32'(req_ready), 32'b1100);
    chk("t2b acc_index_0", 32'(acc_index_0), 3);
    chk("t2b acc_cmd_0", 32'(acc_cmd_0), 2);
    chk("t2b acc_index_1", 32'(acc_index_1), 4);
    push_rsp(2, 0, 4'd3, 2'b10, 2'd2); push_rsp(3, 1, 4'd4, 2'b00, 2'd3);

    // Index conflict between 0 and 1: 1 skipped, then served first
    next_cycle();
    req_valid = 4'b0111;
    set_req(0, 4'd5, 2'b00, 2'd1); set_req(1, 4'd5, 2'b01, 2'd2); set_req(2, 4'd6, 2'b10, 2'd3);
    #1;
    chk("t3a req_ready", 32'(req_ready), 32'b0101);
    chk("t3a acc_index_1", 32'(acc_index_1), 6);
    chk("t3a acc_cmd_1", 32'(acc_cmd_1), 2);
    push_rsp(0, 0, 4'd5, 2'b00, 2'd1); push_rsp(2, 1, 4'd6, 2'b10, 2'd3);
    next_cycle();
    req_valid = 4'b0010;
    #1;
    chk("t3b req_ready", 32'(req_ready), 32'b0010);
    chk("t3b acc_index_0", 32'(acc_index_0), 5);
    chk("t3b acc_cmd_0", 32'(acc_cmd_0), 1);
    chk("t3b acc_req_1", 32'(acc_req_1), 0);
    push_rsp(1, 0, 4'd5, 2'b01, 2'd2);

    // Illegal command from requester 2
    next_cycle();
    req_valid = 4'b0100; set_req(2, 4'd9, 2'b11, 2'd3);
    #1;
    chk("t4 req_ready", 32'(req_ready), 32'b0100);
    chk("t4 acc_req_0", 32'(acc_req_0), 0);
    chk("t4 acc_index_0", 32'(acc_index_0), 0);
    chk("t4 acc_req_1", 32'(acc_req_1), 0);
    push_rsp(2, 2, 4'd9, 2'b11, 2'd3);

    // Frozen issue for three cycles, pointer stays at 3
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      arb_en = 1'b0; req_valid = 4'b1111;
      set_req(0, 4'd1, 2'b00, 2'd0); set_req(1, 4'd2, 2'b01, 2'd1);
      set_req(2, 4'd3, 2'b10, 2'd2); set_req(3, 4'd4, 2'b01, 2'd3);
      #1;
      chk("t5 frozen req_ready", 32'(req_ready), 0);
      chk("t5 frozen acc_req_0", 32'(acc_req_0), 0);
      chk("t5 frozen acc_req_1", 32'(acc_req_1), 0);
    end
    next_cycle();
    arb_en = 1'b1;
    #1;
    chk("t5 resume req_ready", 32'(req_ready), 32'b1001);
    chk("t5 resume acc_index_0", 32'(acc_index_0), 4);
    chk("t5 resume acc_index_1", 32'(acc_index_1), 1);
    push_rsp(3, 0, 4'd4, 2'b01, 2'd3); push_rsp(0, 1, 4'd1, 2'b00, 2'd0);
    next_cycle();
    req_valid = 4'b0110;
    #1;
    chk("t5b req_ready", 32'(req_ready), 32'b0110);
    chk("t5b acc_index_0", 32'(acc_index_0), 2);
    chk("t5b acc_index_1", 32'(acc_index_1), 3);
    push_rsp(1, 0, 4'd2, 2'b01, 2'd1); push_rsp(2, 1, 4'd3, 2'b10, 2'd2);

    // Illegal younger request is passed over for port1 (pointer 3 -> 2)
    next_cycle();
    req_valid = 4'b1011;
    set_req(3, 4'd8, 2'b00, 2'd0); set_req(0, 4'd9, 2'b11, 2'd2); set_req(1, 4'd10, 2'b00, 2'd1);
    #1;
    chk("t4b req_ready", 32'(req_ready), 32'b1010);
    chk("t4b acc_index_1", 32'(acc_index_1), 10);
    push_rsp(3, 0, 4'd8, 2'b00, 2'd0); push_rsp(1, 1, 4'd10, 2'b00, 2'd1);
    next_cycle();
    req_valid = 4'b0001;
    #1;
    chk("t4c req_ready", 32'(req_ready), 32'b0001);
    chk("t4c acc_req_0", 32'(acc_req_0), 0);
    push_rsp(0, 2, 4'd9, 2'b11, 2'd2);

    // Reset right after a grant drops the pending response
    next_cycle();
    req_valid = 4'b0001; set_req(0, 4'd2, 2'b00, 2'd1);
    #1;
    chk("t6 req_ready", 32'(req_ready), 32'b0001);
    next_cycle();
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    chk("t6 rsp_valid", 32'(rsp_valid), 0);
    chk("t6 rsp_status", 32'(rsp_status), 0);
    chk("t6 rsp_tag", 32'(rsp_tag), 0);
    chk("t6 req_ready", 32'(req_ready), 0);
    chk("t6 acc_req_0", 32'(acc_req_0), 0);
    chk("t6 acc_req_1", 32'(acc_req_1), 0);
    next_cycle(); next_cycle();

    // Eight back-to-back conflicting cycles, 0 and 1 alternate on port0
    rst_n = 1'b1;
    set_req(0, 4'd9, 2'b00, 2'd0); set_req(1, 4'd9, 2'b00, 2'd1);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) next_cycle();
      req_valid = 4'b0011;
      #1;
      chk("conf req_ready", 32'(req_ready), (c % 2 == 0) ? 32'b0001 : 32'b0010);
      chk("conf acc_req_1", 32'(acc_req_1), 0);
      push_rsp(c % 2, 0, 4'd9, 2'b00, 2'(c % 2));
    end
    next_cycle();
    req_valid = 4'b0000;
`ifdef ARB_STATS_EN
    #1;
    chk("stat_conflict_cnt", 32'(stat_conflict_cnt), 8);
    chk("stat_grant_cnt", stat_grant_cnt, 8);
    stat_clr = 1'b1;
    next_cycle();
    stat_clr = 1'b0;
    chk("stat_conflict_cnt clr", 32'(stat_conflict_cnt), 0);
    chk("stat_grant_cnt clr", stat_grant_cnt, 0);
`endif

    repeat (3) next_cycle();
    chk("scoreboard drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
